// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes, selects.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADDR = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RWB     = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_IEXEC   = 4'd10,
        ST_IWB     = 4'd11,
        ST_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that wait on MemRdy and are guarded by the timeout counter.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// Memory-wait counter: counts stalled cycles; hit_o once TIMEOUT stalls have elapsed.
module mc_wait_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // hit_o is the registered count having reached TIMEOUT, so a MemRdy in
    // that same cycle can still complete the access.
    always_comb begin
        hit_o = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !hit_o && (TIMEOUT != 0))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-style control FSM with memory-wait timeout and sticky trap.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter bit          EN_EXT  = 1'b1,
    parameter int unsigned OP_W    = 6
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [OP_W-1:0] Op,
    input  logic            MemRdy,
    output logic            RegWr,
    output logic            MemRd,
    output logic            MemWr,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            IRWr,
    output logic            IorD,
    output logic            PCWr,
    output logic            PCWrCond,
    output logic            PCWrCondN,
    output logic            ALUSrcA,
    output logic [1:0]      PCSrc,
    output logic [1:0]      ALUOp,
    output logic [1:0]      ALUSrcB,
    output logic            Retire,
    output logic            Trap,
    output logic [3:0]      State
);

    state_t state_q, state_d;
    logic   hit, cnt_clr, cnt_inc;
    logic   is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_addi;

    assign is_r    = (Op == OP_W'(OP_RTYPE));
    assign is_lw   = (Op == OP_W'(OP_LW));
    assign is_sw   = (Op == OP_W'(OP_SW));
    assign is_beq  = (Op == OP_W'(OP_BEQ));
    assign is_bne  = (Op == OP_W'(OP_BNE))  && EN_EXT;
    assign is_j    = (Op == OP_W'(OP_J));
    assign is_addi = (Op == OP_W'(OP_ADDI)) && EN_EXT;

    // Any state change restarts the count, so each memory state starts from zero.
    assign cnt_clr = (state_d != state_q);
    assign cnt_inc = is_mem_state(state_q) && !MemRdy;
    assign State   = state_q;

    mc_wait_cnt #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
        .clk_i  (Clock),
        .rstn_i (Resetn),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .hit_o  (hit)
    );

    // State register; reset returns to FETCH from anywhere, including TRAP.
    always_ff @(posedge Clock) begin
        if (!Resetn)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d   = state_q;
        RegWr     = 1'b0;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        IRWr      = 1'b0;
        IorD      = 1'b0;
        PCWr      = 1'b0;
        PCWrCond  = 1'b0;
        PCWrCondN = 1'b0;
        ALUSrcA   = 1'b0;
        PCSrc     = PC_ALU;
        ALUOp     = ALU_ADD;
        ALUSrcB   = SRCB_REG;
        Retire    = 1'b0;
        Trap      = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                MemRd   = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemRdy) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = ST_DECODE;
                end else if (hit) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_BOFF;
                if (is_r)                state_d = ST_EXEC;
                else if (is_lw || is_sw) state_d = ST_MEMADDR;
                else if (is_beq || is_bne) state_d = ST_BRANCH;
                else if (is_j)           state_d = ST_JUMP;
                else if (is_addi)        state_d = ST_IEXEC;
                else                     state_d = ST_TRAP;
            end
            ST_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                if (is_lw)      state_d = ST_MEMRD;
                else if (is_sw) state_d = ST_MEMWR;
                else            state_d = ST_TRAP;
            end
            ST_MEMRD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
                if (MemRdy)   state_d = ST_MEMWB;
                else if (hit) state_d = ST_TRAP;
            end
            ST_MEMWB: begin
                RegWr    = 1'b1;
                MemtoReg = 1'b1;
                Retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEMWR: begin
                MemWr = 1'b1;
                IorD  = 1'b1;
                if (MemRdy) begin
                    Retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (hit) begin
                    state_d = ST_TRAP;
                end
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = ST_RWB;
            end
            ST_RWB: begin
                RegWr   = 1'b1;
                RegDst  = 1'b1;
                Retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALU_SUB;
                PCSrc     = PC_ALUOUT;
                PCWrCond  = is_beq;
                PCWrCondN = is_bne;
                Retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                PCSrc   = PC_JUMP;
                PCWr    = 1'b1;
                Retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = ST_IWB;
            end
            ST_IWB: begin
                RegWr   = 1'b1;
                Retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                Trap = 1'b1;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench: vector table driven through a scoreboard, two parameterisations.
module tb_mc_ctrl_fsm;
    import mc_pkg::*;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [5:0] Op;
    logic       MemRdy;

    logic a_RegWr, a_MemRd, a_MemWr, a_RegDst, a_MemtoReg, a_IRWr, a_IorD, a_PCWr;
    logic a_PCWrCond, a_PCWrCondN, a_ALUSrcA, a_Retire, a_Trap;
    logic [1:0] a_PCSrc, a_ALUOp, a_ALUSrcB;
    logic [3:0] a_State;
    logic b_RegWr, b_MemRd, b_MemWr, b_RegDst, b_MemtoReg, b_IRWr, b_IorD, b_PCWr;
    logic b_PCWrCond, b_PCWrCondN, b_ALUSrcA, b_Retire, b_Trap;
    logic [1:0] b_PCSrc, b_ALUOp, b_ALUSrcB;
    logic [3:0] b_State;

    always #5 Clock = ~Clock;

    mc_ctrl_fsm #(.TIMEOUT(4), .EN_EXT(1'b1), .OP_W(6)) u_dut (
        .Clock(Clock), .Resetn(Resetn), .Op(Op), .MemRdy(MemRdy),
        .RegWr(a_RegWr), .MemRd(a_MemRd), .MemWr(a_MemWr), .RegDst(a_RegDst),
        .MemtoReg(a_MemtoReg), .IRWr(a_IRWr), .IorD(a_IorD), .PCWr(a_PCWr),
        .PCWrCond(a_PCWrCond), .PCWrCondN(a_PCWrCondN), .ALUSrcA(a_ALUSrcA),
        .PCSrc(a_PCSrc), .ALUOp(a_ALUOp), .ALUSrcB(a_ALUSrcB),
        .Retire(a_Retire), .Trap(a_Trap), .State(a_State)
    );

    mc_ctrl_fsm #(.TIMEOUT(4), .EN_EXT(1'b0), .OP_W(6)) u_dut_noext (
        .Clock(Clock), .Resetn(Resetn), .Op(Op), .MemRdy(MemRdy),
        .RegWr(b_RegWr), .MemRd(b_MemRd), .MemWr(b_MemWr), .RegDst(b_RegDst),
        .MemtoReg(b_MemtoReg), .IRWr(b_IRWr), .IorD(b_IorD), .PCWr(b_PCWr),
        .PCWrCond(b_PCWrCond), .PCWrCondN(b_PCWrCondN), .ALUSrcA(b_ALUSrcA),
        .PCSrc(b_PCSrc), .ALUOp(b_ALUOp), .ALUSrcB(b_ALUSrcB),
        .Retire(b_Retire), .Trap(b_Trap), .State(b_State)
    );

    // Packed view: {State, RegWr, MemRd, MemWr, RegDst, MemtoReg, IRWr, IorD, PCWr,
    //               PCWrCond, PCWrCondN, ALUSrcA, PCSrc, ALUOp, ALUSrcB, Retire, Trap}
    logic [22:0] act_a, act_b;
    assign act_a = {a_State, a_RegWr, a_MemRd, a_MemWr, a_RegDst, a_MemtoReg, a_IRWr,
                    a_IorD, a_PCWr, a_PCWrCond, a_PCWrCondN, a_ALUSrcA, a_PCSrc,
                    a_ALUOp, a_ALUSrcB, a_Retire, a_Trap};
    assign act_b = {b_State, b_RegWr, b_MemRd, b_MemWr, b_RegDst, b_MemtoReg, b_IRWr,
                    b_IorD, b_PCWr, b_PCWrCond, b_PCWrCondN, b_ALUSrcA, b_PCSrc,
                    b_ALUOp, b_ALUSrcB, b_Retire, b_Trap};

    // Reference output table per state, written from the control-signal listing.
    function automatic logic [22:0] exp_out(input state_t s, input logic [5:0] op, input logic rdy);
        logic rw, mr, mw, rd, m2r, irw, iord, pcw, pcc, pccn, asa, ret, trp;
        logic [1:0] pcs, aop, asb;
        {rw, mr, mw, rd, m2r, irw, iord, pcw, pcc, pccn, asa, ret, trp} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (s)
            ST_FETCH:   begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            ST_DECODE:  begin asb = 2'b11; end
            ST_MEMADDR: begin asa = 1; asb = 2'b10; end
            ST_MEMRD:   begin mr = 1; iord = 1; end
            ST_MEMWB:   begin rw = 1; m2r = 1; ret = 1; end
            ST_MEMWR:   begin mw = 1; iord = 1; ret = rdy; end
            ST_EXEC:    begin asa = 1; aop = 2'b10; end
            ST_RWB:     begin rw = 1; rd = 1; ret = 1; end
            ST_BRANCH:  begin asa = 1; aop = 2'b01; pcs = 2'b01; ret = 1;
                              pcc = (op == BEQ); pccn = (op == BNE); end
            ST_JUMP:    begin pcs = 2'b10; pcw = 1; ret = 1; end
            ST_IEXEC:   begin asa = 1; asb = 2'b10; end
            ST_IWB:     begin rw = 1; ret = 1; end
            ST_TRAP:    begin trp = 1; end
            default:    begin end
        endcase
        return {s, rw, mr, mw, rd, m2r, irw, iord, pcw, pcc, pccn, asa, pcs, aop, asb, ret, trp};
    endfunction

    typedef struct {
        logic       rstn;
        logic [5:0] op;
        logic       rdy;
        state_t     st_a;
        state_t     st_b;
    } vec_t;

    typedef struct {
        int          id;
        logic [22:0] ea;
        logic [22:0] eb;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic rn, input logic [5:0] op, input logic rdy,
                       input state_t sa, input state_t sb_st);
        vec_t v;
        v.rstn = rn; v.op = op; v.rdy = rdy; v.st_a = sa; v.st_b = sb_st;
        vecs.push_back(v);
    endtask

    task automatic step(input logic rn, input logic [5:0] op, input logic rdy,
                        input state_t sa, input state_t sb_st, input int id);
        sb_t e;
        Resetn = rn; Op = op; MemRdy = rdy;
        e.id = id; e.ea = exp_out(sa, op, rdy); e.eb = exp_out(sb_st, op, rdy);
        sb.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    // Outputs are combinational; compare mid-cycle against the queued expectation.
    always @(negedge Clock) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (act_a === mon_e.ea) n_pass++;
            else $display("FAIL step%0d ext1: got %h expected %h", mon_e.id, act_a, mon_e.ea);
            n_checks++;
            if (act_b === mon_e.eb) n_pass++;
            else $display("FAIL step%0d ext0: got %h expected %h", mon_e.id, act_b, mon_e.eb);
        end
    end

    initial begin
        // R-type
        add(1, R, 1, ST_FETCH, ST_FETCH);
        add(1, R, 1, ST_DECODE, ST_DECODE);
        add(1, R, 1, ST_EXEC, ST_EXEC);
        add(1, R, 1, ST_RWB, ST_RWB);
        // lw, MemRdy late by 3 cycles
        add(1, LW, 1, ST_FETCH, ST_FETCH);
        add(1, LW, 1, ST_DECODE, ST_DECODE);
        add(1, LW, 1, ST_MEMADDR, ST_MEMADDR);
        for (int i = 0; i < 3; i++) add(1, LW, 0, ST_MEMRD, ST_MEMRD);
        add(1, LW, 1, ST_MEMRD, ST_MEMRD);
        add(1, LW, 0, ST_MEMWB, ST_MEMWB);
        // sw
        add(1, SW, 1, ST_FETCH, ST_FETCH);
        add(1, SW, 1, ST_DECODE, ST_DECODE);
        add(1, SW, 1, ST_MEMADDR, ST_MEMADDR);
        add(1, SW, 0, ST_MEMWR, ST_MEMWR);
        add(1, SW, 1, ST_MEMWR, ST_MEMWR);
        // beq
        add(1, BEQ, 1, ST_FETCH, ST_FETCH);
        add(1, BEQ, 1, ST_DECODE, ST_DECODE);
        add(1, BEQ, 1, ST_BRANCH, ST_BRANCH);
        // bne: branch with extensions, trap without
        add(1, BNE, 1, ST_FETCH, ST_FETCH);
        add(1, BNE, 1, ST_DECODE, ST_DECODE);
        add(1, BNE, 1, ST_BRANCH, ST_TRAP);
        // j, addi, illegal: second instance stays trapped
        add(1, J, 1, ST_FETCH, ST_TRAP);
        add(1, J, 1, ST_DECODE, ST_TRAP);
        add(1, J, 1, ST_JUMP, ST_TRAP);
        add(1, ADDI, 1, ST_FETCH, ST_TRAP);
        add(1, ADDI, 1, ST_DECODE, ST_TRAP);
        add(1, ADDI, 1, ST_IEXEC, ST_TRAP);
        add(1, ADDI, 1, ST_IWB, ST_TRAP);
        add(1, BAD, 1, ST_FETCH, ST_TRAP);
        add(1, BAD, 1, ST_DECODE, ST_TRAP);
        add(1, BAD, 1, ST_TRAP, ST_TRAP);
        add(1, BAD, 1, ST_TRAP, ST_TRAP);
        add(0, R, 0, ST_TRAP, ST_TRAP);
        // fetch timeout: four stalls, then trap on a fifth stalled cycle
        for (int i = 0; i < 5; i++) add(1, R, 0, ST_FETCH, ST_FETCH);
        add(1, R, 0, ST_TRAP, ST_TRAP);
        add(1, R, 1, ST_TRAP, ST_TRAP);
        add(0, R, 0, ST_TRAP, ST_TRAP);
        // MemRdy arriving exactly at the timeout completes the fetch
        for (int i = 0; i < 4; i++) add(1, R, 0, ST_FETCH, ST_FETCH);
        add(1, R, 1, ST_FETCH, ST_FETCH);
        add(1, R, 1, ST_DECODE, ST_DECODE);
        add(1, R, 1, ST_EXEC, ST_EXEC);
        add(1, R, 1, ST_RWB, ST_RWB);
        // reset during MEMWR wait
        add(1, SW, 1, ST_FETCH, ST_FETCH);
        add(1, SW, 1, ST_DECODE, ST_DECODE);
        add(1, SW, 1, ST_MEMADDR, ST_MEMADDR);
        add(1, SW, 0, ST_MEMWR, ST_MEMWR);
        add(0, SW, 0, ST_MEMWR, ST_MEMWR);
        add(1, LW, 0, ST_FETCH, ST_FETCH);
        // counter restarts in MEMRD after stalls in FETCH, then times out there
        add(1, LW, 1, ST_FETCH, ST_FETCH);
        add(1, LW, 1, ST_DECODE, ST_DECODE);
        add(1, LW, 1, ST_MEMADDR, ST_MEMADDR);
        for (int i = 0; i < 5; i++) add(1, LW, 0, ST_MEMRD, ST_MEMRD);
        add(1, LW, 0, ST_TRAP, ST_TRAP);

        Resetn = 1'b0; Op = R; MemRdy = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rstn, vecs[i].op, vecs[i].rdy, vecs[i].st_a, vecs[i].st_b, i);

        // Reset in the middle of a MEMRD wait lands in FETCH with no retire.
        step(0, R,  0, ST_TRAP,    ST_TRAP,    101);
        step(1, LW, 1, ST_FETCH,   ST_FETCH,   102);
        step(1, LW, 1, ST_DECODE,  ST_DECODE,  103);
        step(1, LW, 1, ST_MEMADDR, ST_MEMADDR, 104);
        step(0, LW, 0, ST_MEMRD,   ST_MEMRD,   105);
        step(1, LW, 0, ST_FETCH,   ST_FETCH,   106);
        step(1, LW, 1, ST_FETCH,   ST_FETCH,   107);

        @(negedge Clock);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT, 16, max memory-wait cycles per access; 0 disables the timeout.
REQ-002 SHALL have parameter EN_EXT, 1, enables bne/addi; when 0 these opcodes are illegal.
REQ-003 SHALL have parameter OP_W, 6, opcode width.
REQ-004 SHALL have port Clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port Resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port Op  in  OP_W  opcode, Inst[31:26].
REQ-007 SHALL have port MemRdy  in  1  memory access completes this cycle.
REQ-008 SHALL have ports RegWr, MemRd, MemWr, RegDst, MemtoReg, IRWr, IorD, PCWr, PCWrCond, PCWrCondN, ALUSrcA  out  1 each  datapath controls; PCWrCondN is the branch-if-not-zero enable.
REQ-009 SHALL have ports PCSrc, ALUOp, ALUSrcB  out  2 each  mux/ALU selects; ALUOp 00=add, 01=sub, 10=funct.
REQ-010 SHALL have ports Retire  out  1  one-cycle pulse per completed instruction; Trap  out  1  sticky fault; State  out  4  current state code.

Function
REQ-011 SHALL implement states FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, IEXEC, IWB, TRAP.
REQ-012 FETCH SHALL drive MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00 and hold them until MemRdy=1; IRWr=PCWr=1 only in the MemRdy=1 cycle; next state DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and branch on Op: 000000->EXEC, 100011/101011->MEMADDR, 000100/000101->BRANCH, 000010->JUMP, 001000->IEXEC, else TRAP.
REQ-014 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD for lw, MEMWR for sw.
REQ-015 MEMRD (MemRd=1, IorD=1) SHALL wait for MemRdy, then go to MEMWB (RegWr=1, RegDst=0, MemtoReg=1) then FETCH.
REQ-016 MEMWR SHALL drive MemWr=1, IorD=1, wait for MemRdy, then go to FETCH.
REQ-017 EXEC (ALUSrcA=1, ALUSrcB=00, ALUOp=10) SHALL go to RWB (RegWr=1, RegDst=1, MemtoReg=0) then FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, with PCWrCond=1 for beq or PCWrCondN=1 for bne; next FETCH.
REQ-019 JUMP SHALL drive PCSrc=10, PCWr=1; next FETCH.
REQ-020 IEXEC (ALUSrcA=1, ALUSrcB=10, ALUOp=00) SHALL go to IWB (RegWr=1, RegDst=0, MemtoReg=0) then FETCH.
REQ-021 Every output not listed for a state SHALL be 0 in that state.
REQ-022 Retire SHALL pulse in the final cycle of MEMWB, MEMWR (MemRdy=1), RWB, BRANCH, JUMP and IWB.
REQ-023 A wait counter SHALL clear on entry to each memory state and increment each cycle MemRdy=0; reaching TIMEOUT (TIMEOUT>0) SHALL go to TRAP.
REQ-024 MemRdy=1 in the same cycle the counter reaches TIMEOUT SHALL complete the access, with no trap.
REQ-025 MemRdy SHALL be ignored outside FETCH, MEMRD and MEMWR.
REQ-026 TRAP SHALL drive all controls 0 and Trap=1, and SHALL be left only by reset.
REQ-027 With EN_EXT=0, opcodes 000101 and 001000 SHALL go to TRAP from DECODE.

Reset
REQ-028 Resetn=0 at a rising edge SHALL force FETCH, clear the wait counter and Trap, and zero Retire, from any state including mid-wait.
REQ-029 All outputs SHALL be combinational from state plus Op/MemRdy; in the cycle after reset they SHALL equal the FETCH values with IRWr=PCWr=0 unless MemRdy=1.

Structure
REQ-030 State encodings, opcode constants and ALUOp codes SHALL live in the shared package mc_pkg.
REQ-031 Wait counter SHALL be sub-module mc_wait_cnt (clear, inc, hit output at TIMEOUT).

Verification
REQ-032 Reset, MemRdy=1 always, Op=000000 -> states FETCH,DECODE,EXEC,RWB; Retire on cycle 4; RegDst=1 on RWB.
REQ-033 lw with MemRdy delayed 3 cycles in MEMRD -> MemRd=IorD=1 held 4 cycles; MEMWB follows; Retire once.
REQ-034 TIMEOUT=4, MemRdy=0 in FETCH -> TRAP after 4 wait cycles, Trap=1 until Resetn=0, then FETCH.
REQ-035 Op=000101 with EN_EXT=1 -> PCWrCondN=1, PCWrCond=0 in BRANCH; with EN_EXT=0 -> TRAP.
REQ-036 Resetn=0 during MEMWR wait -> next cycle FETCH, MemWr=0, no Retire.
REQ-037 Op=111111 -> TRAP after DECODE; all controls 0.
